// File: rtl/camera_capture_if.sv
// camera_capture_if
//   Bundles the camera-side inputs and the frame-buffer write port of
//   camera_capture. Clock and reset stay outside as plain ports.
//
//   Camera side : VSYNC, HREF, input_data, ENABLE, MODE
//   Write side  : output_data, X_ADDR, Y_ADDR, W_EN
//   Status      : FRAME_DONE, LINE_ERR, FRAME_CNT
//
// Handshake: the write port is a strobe with no back-pressure.
// output_data/X_ADDR/Y_ADDR are meaningful only while W_EN is high.
// W_EN is high for exactly one cycle per pixel. The frame-buffer RAM must
// accept the write on that cycle. There is no ready signal.
interface camera_capture_if #(
  parameter int ADDR_W = 15
);
  logic              VSYNC;
  logic              HREF;
  logic [7:0]        input_data;
  logic              ENABLE;
  logic [1:0]        MODE;
  logic [7:0]        output_data;
  logic [ADDR_W-1:0] X_ADDR;
  logic [ADDR_W-1:0] Y_ADDR;
  logic              W_EN;
  logic              FRAME_DONE;
  logic              LINE_ERR;
  logic [7:0]        FRAME_CNT;

  // master: camera pins and host controls, consumer of writes and status
  modport master (
    output VSYNC, HREF, input_data, ENABLE, MODE,
    input  output_data, X_ADDR, Y_ADDR, W_EN, FRAME_DONE, LINE_ERR, FRAME_CNT
  );

  // slave: the capture block itself
  modport slave (
    input  VSYNC, HREF, input_data, ENABLE, MODE,
    output output_data, X_ADDR, Y_ADDR, W_EN, FRAME_DONE, LINE_ERR, FRAME_CNT
  );
endinterface

// File: rtl/camera_capture.sv
// camera_capture
//   Converts the OV7670 VSYNC/HREF/byte stream into single-byte pixel writes
//   for the frame-buffer RAM. The pixel format is selected at run time:
//   RGB565 or RGB444 is converted to RGB332, Y8 is passed through, and a
//   test pattern can be generated. The block supports power-of-two
//   decimation, counts completed frames and flags bad line lengths.
//
//   Ports:
//     CLK         camera pixel clock (rising edge)
//     RESET_N     asynchronous active-low reset
//     cam         camera_capture_if.slave (camera inputs, write port, status)
//     dbg_state_o current frame FSM state (0 IDLE, 1 SYNC, 2 ACTIVE, 3 DONE)
module camera_capture #(
  parameter int H_PIXELS = 176,
  parameter int V_LINES  = 144,
  parameter int ADDR_W   = 15,
  parameter int DECIM    = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  camera_capture_if.slave cam,
  output logic [1:0]      dbg_state_o
);
  // Raw counters are wider than the address so that DECIM*H_PIXELS and
  // oversized lines still compare correctly against the limits.
  localparam int CNT_W = ADDR_W + 3;
  localparam int SH    = $clog2(DECIM);
  localparam logic [CNT_W-1:0] MASK  = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_LINES);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_DONE} state_e;

  state_e state_q, state_d;

  logic              vsync_q;
  logic              in_line_q, in_line_d;
  logic              phase_q, phase_d;
  logic [6:0]        b1_q, b1_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  pix_q, pix_d;
  logic [CNT_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              line_err_q, line_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              wen_q, wen_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;

  logic frame_start, capture, frame_end, frame_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cam.ENABLE && cam.VSYNC) state_d = S_SYNC;
      S_SYNC:   if (frame_start) state_d = S_ACTIVE;
      S_ACTIVE: if (frame_end) state_d = S_DONE;
      S_DONE:   state_d = cam.ENABLE ? S_SYNC : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    frame_start = (state_q == S_SYNC) && vsync_q && !cam.VSYNC;
    // A byte sampled together with VSYNC high is part of the frame end and
    // is discarded.
    capture     = (state_q == S_ACTIVE) && !cam.VSYNC;
    frame_end   = (state_q == S_ACTIVE) && cam.VSYNC;
    frame_done  = (state_q == S_DONE);
  end

  // ---------------- pixel datapath ----------------
  logic             pix_done, keep_col, keep_line;
  logic [CNT_W-1:0] x_raw, y_raw;
  logic [7:0]       pix_val;

  always_comb begin
    pix_done  = capture && cam.HREF && ((mode_q == 2'd2) || phase_q);
    x_raw     = pix_q >> SH;
    y_raw     = line_q >> SH;
    keep_col  = (pix_q & MASK) == '0;
    keep_line = ((line_q & MASK) == '0) && (y_raw < V_LIM);
    // b1_q holds first-byte bits {7:5, 3:0}. Bit 4 is unused in every format.
    case (mode_q)
      2'd0:    pix_val = {b1_q[6:4], b1_q[2:0], cam.input_data[4:3]};
      2'd1:    pix_val = {b1_q[3:1], cam.input_data[7:5], cam.input_data[3:2]};
      2'd2:    pix_val = cam.input_data;
      default: pix_val = x_raw[7:0] ^ y_raw[7:0];
    endcase
  end

  always_comb begin
    in_line_d   = in_line_q;
    phase_d     = phase_q;
    b1_d        = b1_q;
    mode_d      = mode_q;
    pix_d       = pix_q;
    line_d      = line_q;
    wr_cnt_d    = wr_cnt_q;
    line_err_d  = line_err_q;
    frame_cnt_d = frame_cnt_q;
    wen_d       = 1'b0;
    data_d      = data_q;
    x_d         = x_q;
    y_d         = y_q;
    if (frame_start) begin
      mode_d     = cam.MODE;
      in_line_d  = 1'b0;
      phase_d    = 1'b0;
      pix_d      = '0;
      line_d     = '0;
      wr_cnt_d   = '0;
      line_err_d = 1'b0;
    end else if (capture) begin
      if (cam.HREF) begin
        in_line_d = 1'b1;
        phase_d   = ~phase_q;
        if (!phase_q) b1_d = {cam.input_data[7:5], cam.input_data[3:0]};
        if (pix_done) begin
          pix_d = sat_inc(pix_q);
          if (keep_col && keep_line) begin
            if (x_raw < H_LIM) begin
              wen_d    = 1'b1;
              x_d      = x_raw[ADDR_W-1:0];
              y_d      = y_raw[ADDR_W-1:0];
              data_d   = pix_val;
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end else begin
              line_err_d = 1'b1;
            end
          end
        end
      end else begin
        // HREF low: a dangling odd byte is dropped. If a line was open,
        // this is its falling edge.
        phase_d = 1'b0;
        if (in_line_q) begin
          in_line_d = 1'b0;
          line_d    = sat_inc(line_q);
          pix_d     = '0;
          wr_cnt_d  = '0;
          if (keep_line && (wr_cnt_q < H_LIM)) line_err_d = 1'b1;
        end
      end
    end else if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      phase_d     = 1'b0;
      in_line_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vsync_q     <= 1'b0;
      in_line_q   <= 1'b0;
      phase_q     <= 1'b0;
      b1_q        <= '0;
      mode_q      <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      wr_cnt_q    <= '0;
      line_err_q  <= 1'b0;
      frame_cnt_q <= '0;
      wen_q       <= 1'b0;
      data_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      vsync_q     <= cam.VSYNC;
      in_line_q   <= in_line_d;
      phase_q     <= phase_d;
      b1_q        <= b1_d;
      mode_q      <= mode_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      wr_cnt_q    <= wr_cnt_d;
      line_err_q  <= line_err_d;
      frame_cnt_q <= frame_cnt_d;
      wen_q       <= wen_d;
      data_q      <= data_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign cam.output_data = data_q;
  assign cam.X_ADDR      = x_q;
  assign cam.Y_ADDR      = y_q;
  assign cam.W_EN        = wen_q;
  assign cam.FRAME_DONE  = frame_done;
  assign cam.LINE_ERR    = line_err_q;
  assign cam.FRAME_CNT   = frame_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_camera_capture.sv
// Testbench for camera_capture. It uses a reduced 8x4 frame so that every
// scenario runs in a few thousand cycles. Instance dut_a uses DECIM=1 and
// instance dut_b uses DECIM=2. Both instances see the same camera stream.
module tb_camera_capture;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 15;
  localparam int W  = 38;  // {Y[14:0], X[14:0], data[7:0]}

  logic       clk;
  logic       rst_n;
  logic [1:0] st_a, st_b;

  camera_capture_if #(.ADDR_W(AW)) ifa ();
  camera_capture_if #(.ADDR_W(AW)) ifb ();

  camera_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .DECIM(1)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .cam(ifa), .dbg_state_o(st_a));
  camera_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .DECIM(2)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .cam(ifb), .dbg_state_o(st_b));

  assign ifb.VSYNC      = ifa.VSYNC;
  assign ifb.HREF       = ifa.HREF;
  assign ifb.input_data = ifa.input_data;
  assign ifb.ENABLE     = ifa.ENABLE;
  assign ifb.MODE       = ifa.MODE;

  int checks   = 0;
  int errors   = 0;
  int fd_a     = 0;
  int exp_fcnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_a[$];
  logic [W-1:0] obs_b[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Writes are sampled on the falling edge.
  always @(negedge clk) begin
    if (ifa.W_EN === 1'b1) obs_a.push_back({ifa.Y_ADDR, ifa.X_ADDR, ifa.output_data});
    if (ifb.W_EN === 1'b1) obs_b.push_back({ifb.Y_ADDR, ifb.X_ADDR, ifb.output_data});
    if (ifa.FRAME_DONE === 1'b1) fd_a++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    ifa.HREF  = 1'b0;
    ifa.VSYNC = 1'b1;
    repeat (3) cyc();
    ifa.VSYNC = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic frame_end();
    ifa.HREF  = 1'b0;
    ifa.VSYNC = 1'b1;
    repeat (3) cyc();
  endtask

  // kind 0: alternating word bytes, 1: byte = column index, 2: random
  task automatic send_bytes(input int from, input int to, input int kind, input logic [15:0] word);
    for (int i = from; i < to; i++) begin
      ifa.HREF = 1'b1;
      case (kind)
        0:       ifa.input_data = (i % 2 == 0) ? word[15:8] : word[7:0];
        1:       ifa.input_data = 8'(i);
        default: ifa.input_data = 8'($urandom_range(0, 255));
      endcase
      cyc();
    end
  endtask

  task automatic end_line();
    ifa.HREF = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic send_line(input int n, input int kind, input logic [15:0] word);
    send_bytes(0, n, kind, word);
    end_line();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got [10];
    string nm [10];
    rst_n          = 1'b0;
    ifa.VSYNC      = 1'b0;
    ifa.HREF       = 1'b0;
    ifa.input_data = 8'h00;
    ifa.ENABLE     = 1'b0;
    ifa.MODE       = 2'd0;
    repeat (3) cyc();
    nm = '{"w_en", "frame_done", "line_err", "x_addr", "y_addr", "data",
           "frame_cnt", "state_a", "w_en_b", "state_b"};
    got[0] = 32'(ifa.W_EN);   got[1] = 32'(ifa.FRAME_DONE); got[2] = 32'(ifa.LINE_ERR);
    got[3] = 32'(ifa.X_ADDR); got[4] = 32'(ifa.Y_ADDR);     got[5] = 32'(ifa.output_data);
    got[6] = 32'(ifa.FRAME_CNT); got[7] = 32'(st_a);        got[8] = 32'(ifb.W_EN);
    got[9] = 32'(st_b);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_%s: got %0h want 0", nm[i], got[i]);
      end
    end
    rst_n = 1'b1;
    cyc();
  endtask

  // RGB565 F81F -> RGB332 E3 on every pixel, plus first-pixel latency.
  task automatic test_rgb565();
    int fd0;
    ifa.MODE = 2'd0;
    ifa.ENABLE = 1'b1;
    exp_q.delete();
    obs_a.delete();
    fd0 = fd_a;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back({15'(y), 15'(x), 8'hE3});
    frame_start();
    ifa.HREF = 1'b1;
    ifa.input_data = 8'hF8;
    cyc();
    checks++;
    if (ifa.W_EN !== 1'b0) begin
      errors++;
      $display("FAIL rgb565_first_byte_wen: got %b want 0", ifa.W_EN);
    end
    ifa.input_data = 8'h1F;
    cyc();
    checks++;
    if ({ifa.W_EN, ifa.X_ADDR, ifa.Y_ADDR, ifa.output_data} !== {1'b1, 15'd0, 15'd0, 8'hE3}) begin
      errors++;
      $display("FAIL rgb565_first_pixel: got wen=%b x=%0d y=%0d d=%h want wen=1 x=0 y=0 d=e3",
               ifa.W_EN, ifa.X_ADDR, ifa.Y_ADDR, ifa.output_data);
    end
    send_bytes(2, 2 * H, 0, 16'hF81F);
    end_line();
    for (int l = 1; l < V; l++) send_line(2 * H, 0, 16'hF81F);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rgb565_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rgb565_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (fd_a - fd0 !== 1) begin
      errors++;
      $display("FAIL rgb565_frame_done: got %0d pulses want 1", fd_a - fd0);
    end
    checks++;
    if ({ifa.FRAME_CNT, ifa.LINE_ERR} !== {8'(exp_fcnt), 1'b0}) begin
      errors++;
      $display("FAIL rgb565_status: got cnt=%0d err=%b want cnt=%0d err=0", ifa.FRAME_CNT, ifa.LINE_ERR, exp_fcnt);
    end
  endtask

  // Y8 with DECIM=2 on dut_b: 16x8 raw bytes = column index -> 8x4 writes of 2x.
  task automatic test_decim();
    ifa.MODE = 2'd2;
    exp_q.delete();
    obs_b.delete();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back({15'(y), 15'(x), 8'(2 * x)});
    frame_start();
    for (int l = 0; l < 2 * V; l++) send_line(2 * H, 1, 16'h0000);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_b.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL decim_count: got %0d want %0d", obs_b.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_b.size(); i++) begin
      checks++;
      if (obs_b[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL decim_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_b[i][37:23], obs_b[i][22:8], obs_b[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if ({ifb.FRAME_CNT, ifb.LINE_ERR} !== {8'(exp_fcnt), 1'b0}) begin
      errors++;
      $display("FAIL decim_status: got cnt=%0d err=%b want cnt=%0d err=0", ifb.FRAME_CNT, ifb.LINE_ERR, exp_fcnt);
    end
  endtask

  // Test pattern: random input bytes are ignored, data = X ^ Y.
  task automatic test_pattern();
    ifa.MODE = 2'd3;
    exp_q.delete();
    obs_a.delete();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back({15'(y), 15'(x), 8'(x ^ y)});
    frame_start();
    for (int l = 0; l < V; l++) send_line(2 * H, 2, 16'h0000);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL pattern_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pattern_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
  endtask

  // RGB444 5A,C6 -> {101,110,01} = B9. Line 3 carries only 5 pixels.
  task automatic test_short_line();
    ifa.MODE = 2'd1;
    exp_q.delete();
    obs_a.delete();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < ((y == 3) ? 5 : H); x++) exp_q.push_back({15'(y), 15'(x), 8'hB9});
    frame_start();
    for (int l = 0; l < 3; l++) send_line(2 * H, 0, 16'h5AC6);
    checks++;
    if (ifa.LINE_ERR !== 1'b0) begin
      errors++;
      $display("FAIL short_err_before: got %b want 0", ifa.LINE_ERR);
    end
    send_line(10, 0, 16'h5AC6);
    checks++;
    if (ifa.LINE_ERR !== 1'b1) begin
      errors++;
      $display("FAIL short_err_after: got %b want 1", ifa.LINE_ERR);
    end
    frame_end();
    exp_fcnt++;
    checks++;
    if (ifa.LINE_ERR !== 1'b1) begin
      errors++;
      $display("FAIL short_err_sticky: got %b want 1", ifa.LINE_ERR);
    end
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL short_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
    // The next frame start clears the flag. This frame has no lines.
    frame_start();
    checks++;
    if (ifa.LINE_ERR !== 1'b0) begin
      errors++;
      $display("FAIL short_err_cleared: got %b want 0", ifa.LINE_ERR);
    end
    frame_end();
    exp_fcnt++;
  endtask

  // RGB565 07E0 -> 1C. Line 1 has 10 pixels; X=8,9 are dropped and flagged.
  task automatic test_long_line();
    ifa.MODE = 2'd0;
    exp_q.delete();
    obs_a.delete();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back({15'(y), 15'(x), 8'h1C});
    frame_start();
    send_line(2 * H, 0, 16'h07E0);
    checks++;
    if (ifa.LINE_ERR !== 1'b0) begin
      errors++;
      $display("FAIL long_err_before: got %b want 0", ifa.LINE_ERR);
    end
    send_line(2 * H + 4, 0, 16'h07E0);
    checks++;
    if (ifa.LINE_ERR !== 1'b1) begin
      errors++;
      $display("FAIL long_err_after: got %b want 1", ifa.LINE_ERR);
    end
    for (int l = 2; l < V; l++) send_line(2 * H, 0, 16'h07E0);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL long_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL long_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_enable();
    int fd0;
    // Drop ENABLE mid-frame: the frame still completes.
    ifa.MODE = 2'd2;
    ifa.ENABLE = 1'b1;
    exp_q.delete();
    obs_a.delete();
    fd0 = fd_a;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back({15'(y), 15'(x), 8'(x)});
    frame_start();
    send_line(H, 1, 16'h0000);
    send_line(H, 1, 16'h0000);
    ifa.ENABLE = 1'b0;
    send_line(H, 1, 16'h0000);
    send_line(H, 1, 16'h0000);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL enable_drop_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL enable_drop_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if ({fd_a - fd0, 32'(st_a)} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL enable_drop_done: got pulses=%0d state=%0d want pulses=1 state=0", fd_a - fd0, st_a);
    end
    // A frame with ENABLE low is ignored.
    obs_a.delete();
    frame_start();
    send_line(H, 1, 16'h0000);
    send_line(H, 1, 16'h0000);
    checks++;
    if (obs_a.size() !== 0) begin
      errors++;
      $display("FAIL enable_off_writes: got %0d want 0", obs_a.size());
    end
    // Arming while VSYNC is low must wait for a VSYNC high then low sequence.
    ifa.ENABLE = 1'b1;
    send_line(H, 1, 16'h0000);
    send_line(H, 1, 16'h0000);
    checks++;
    if ({32'(obs_a.size()), 32'(st_a)} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL enable_arm_wait: got writes=%0d state=%0d want writes=0 state=0", obs_a.size(), st_a);
    end
    exp_q.delete();
    for (int x = 0; x < H; x++) exp_q.push_back({15'd0, 15'(x), 8'(x)});
    frame_start();
    send_line(H, 1, 16'h0000);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL enable_arm_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL enable_arm_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (ifa.FRAME_CNT !== 8'(exp_fcnt)) begin
      errors++;
      $display("FAIL enable_frame_cnt: got %0d want %0d", ifa.FRAME_CNT, exp_fcnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got [7];
    string nm [7];
    ifa.MODE = 2'd0;
    ifa.ENABLE = 1'b1;
    frame_start();
    send_line(2 * H, 0, 16'hF81F);
    send_line(2 * H, 0, 16'hF81F);
    send_bytes(0, 7, 0, 16'hF81F);
    rst_n = 1'b0;
    #1;
    nm = '{"w_en", "x_addr", "y_addr", "data", "frame_cnt", "line_err", "state"};
    got[0] = 32'(ifa.W_EN);        got[1] = 32'(ifa.X_ADDR);    got[2] = 32'(ifa.Y_ADDR);
    got[3] = 32'(ifa.output_data); got[4] = 32'(ifa.FRAME_CNT); got[5] = 32'(ifa.LINE_ERR);
    got[6] = 32'(st_a);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== 32'd0) begin
        errors++;
        $display("FAIL midreset_%s: got %0h want 0", nm[i], got[i]);
      end
    end
    obs_a.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bytes(7, 2 * H, 0, 16'hF81F);
    end_line();
    send_line(2 * H, 0, 16'hF81F);
    frame_end();
    checks++;
    if (obs_a.size() !== 0) begin
      errors++;
      $display("FAIL midreset_rest_writes: got %0d want 0", obs_a.size());
    end
    exp_fcnt = 0;
    exp_q.delete();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back({15'(y), 15'(x), 8'hE3});
    frame_start();
    for (int l = 0; l < V; l++) send_line(2 * H, 0, 16'hF81F);
    frame_end();
    exp_fcnt++;
    checks++;
    if (obs_a.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL midreset_next_count: got %0d want %0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_next_write[%0d]: got y=%0d x=%0d d=%h want y=%0d x=%0d d=%h", i,
                 obs_a[i][37:23], obs_a[i][22:8], obs_a[i][7:0], exp_q[i][37:23], exp_q[i][22:8], exp_q[i][7:0]);
      end
    end
    checks++;
    if (ifa.FRAME_CNT !== 8'(exp_fcnt)) begin
      errors++;
      $display("FAIL midreset_frame_cnt: got %0d want %0d", ifa.FRAME_CNT, exp_fcnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rgb565();
    test_decim();
    test_pattern();
    test_short_line();
    test_long_line();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
